// File: rtl/accel_seq_ctrl_pkg.sv
// Shared definitions for the accelerator sequencer: FSM encoding, UART command bytes, defaults.
// Combinational helpers only; no latency or backpressure of its own.
package accel_seq_ctrl_pkg;

  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_N_WEIGHTS = 16;
  localparam int DEF_N_INPUTS  = 16;
  localparam int DEF_PIPE_LAT  = 2;
  localparam int DEF_TIMEOUT   = 100000;

  localparam logic [7:0] CMD_LOAD = 8'hA5;
  localparam logic [7:0] CMD_RUN  = 8'h5A;
  localparam logic [7:0] CMD_CLR  = 8'hC3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_RUN       = 3'd3,
    S_DRAIN     = 3'd4,
    S_SEND      = 3'd5,
    S_SEND_WAIT = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  // Neuron-select width; a single-neuron layer still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accel_seq_ctrl_if.sv
// Sequencer bus: UART rx/tx handshake, weight-memory write port, MAC strobes and status.
// master = sequencer, slave = UART/datapath side; all strobes are single-cycle, no backpressure except tx_busy.
interface accel_seq_ctrl_if
  import accel_seq_ctrl_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int N_WEIGHTS = DEF_N_WEIGHTS
) ();

  localparam int ADDR_W = $clog2(N_NEURONS * N_WEIGHTS);
  localparam int SEL_W  = sel_width(N_NEURONS);

  logic              rx_done;
  logic [7:0]        rx_data;
  logic              tx_busy;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [7:0]        write_data;
  logic              start_compute;
  logic              mac_en;
  logic [7:0]        mac_data;
  logic              tx_start;
  logic [SEL_W-1:0]  tx_sel;
  logic              busy;
  logic              err;
  logic              loaded;

  modport master (
    input  rx_done, rx_data, tx_busy,
    output write_en, write_addr, write_data, start_compute, mac_en, mac_data,
    output tx_start, tx_sel, busy, err, loaded
  );

  modport slave (
    output rx_done, rx_data, tx_busy,
    input  write_en, write_addr, write_data, start_compute, mac_en, mac_data,
    input  tx_start, tx_sel, busy, err, loaded
  );

endinterface

// File: rtl/accel_seq_ctrl_gap_timer.sv
// Idle-gap watchdog: counts enabled cycles since the last clear; expire is a registered-count compare, 0-cycle.
// Saturates at the limit and holds expire until cleared or disabled; no backpressure.
module gap_timer
  import accel_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr || !en) cnt <= '0;
    else if (cnt != LIMIT)   cnt <= cnt + W'(1);
  end

  assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/accel_seq_ctrl.sv
// UART-driven sequencer: loads weights, streams input bytes to the MAC array, then transmits each neuron result.
// Strobes follow the triggering rx_done by one cycle; only tx_busy throttles it (stray bytes outside LOAD/RUN/IDLE/ERR flag err).
module accel_seq_ctrl
  import accel_seq_ctrl_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int N_WEIGHTS = DEF_N_WEIGHTS,
  parameter int N_INPUTS  = DEF_N_INPUTS,
  parameter int PIPE_LAT  = DEF_PIPE_LAT,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int ADDR_W    = $clog2(N_NEURONS * N_WEIGHTS)
) (
  input logic              clk,
  input logic              reset,
  accel_seq_ctrl_if.master bus
);

  localparam int TOTAL = N_NEURONS * N_WEIGHTS;
  localparam int SEL_W = sel_width(N_NEURONS);
  localparam int CNT_W = 16;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [CNT_W-1:0]  cnt;
  logic              seen_busy;
  logic              timed;
  logic              expire;

  assign timed    = (state == S_LOAD) || (state == S_RUN);
  assign bus.busy = (state != S_IDLE) && (state != S_ERR);

  gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (timed),
    .clr    (bus.rx_done),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      addr_cnt          <= '0;
      cnt               <= '0;
      seen_busy         <= 1'b0;
      bus.write_en      <= 1'b0;
      bus.write_addr    <= '0;
      bus.write_data    <= '0;
      bus.start_compute <= 1'b0;
      bus.mac_en        <= 1'b0;
      bus.mac_data      <= '0;
      bus.tx_start      <= 1'b0;
      bus.tx_sel        <= '0;
      bus.err           <= 1'b0;
      bus.loaded        <= 1'b0;
    end else begin
      bus.write_en      <= 1'b0;
      bus.start_compute <= 1'b0;
      bus.mac_en        <= 1'b0;
      bus.tx_start      <= 1'b0;
      case (state)
        S_IDLE: if (bus.rx_done) begin
          if (bus.rx_data == CMD_LOAD) begin
            state      <= S_LOAD;
            addr_cnt   <= '0;
            bus.loaded <= 1'b0;
          end else if (bus.rx_data == CMD_RUN) begin
            if (bus.loaded) state <= S_START;
            else begin
              state   <= S_ERR;
              bus.err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (bus.rx_done) begin
            bus.write_en   <= 1'b1;
            bus.write_addr <= addr_cnt;
            bus.write_data <= bus.rx_data;
            // Last address completes the set; the counter never wraps.
            if (addr_cnt == ADDR_W'(TOTAL - 1)) begin
              state      <= S_IDLE;
              bus.loaded <= 1'b1;
            end else begin
              addr_cnt <= addr_cnt + ADDR_W'(1);
            end
          end else if (expire) begin
            state      <= S_ERR;
            bus.err    <= 1'b1;
            bus.loaded <= 1'b0;
          end
        end
        S_START: begin
          if (bus.rx_done) bus.err <= 1'b1;
          bus.start_compute <= 1'b1;
          cnt               <= '0;
          state             <= S_RUN;
        end
        S_RUN: begin
          if (bus.rx_done) begin
            bus.mac_en   <= 1'b1;
            bus.mac_data <= bus.rx_data;
            if (cnt == CNT_W'(N_INPUTS - 1)) begin
              state <= S_DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (expire) begin
            state      <= S_ERR;
            bus.err    <= 1'b1;
            bus.loaded <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (bus.rx_done) bus.err <= 1'b1;
          if (cnt == CNT_W'(PIPE_LAT - 1)) begin
            state      <= S_SEND;
            bus.tx_sel <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SEND: begin
          if (bus.rx_done) bus.err <= 1'b1;
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            seen_busy    <= 1'b0;
            state        <= S_SEND_WAIT;
          end
        end
        S_SEND_WAIT: begin
          if (bus.rx_done) bus.err <= 1'b1;
          // A byte is finished only after the UART has visibly gone busy and then idle again.
          if (!seen_busy) begin
            if (bus.tx_busy) seen_busy <= 1'b1;
          end else if (!bus.tx_busy) begin
            if (bus.tx_sel == SEL_W'(N_NEURONS - 1)) state <= S_START;
            else begin
              bus.tx_sel <= bus.tx_sel + SEL_W'(1);
              state      <= S_SEND;
            end
          end
        end
        S_ERR: if (bus.rx_done && bus.rx_data == CMD_CLR) begin
          state   <= S_IDLE;
          bus.err <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Randomized bench for accel_seq_ctrl: a protocol-level model queues expected strobes, a monitor pops and compares.
module tb_accel_seq_ctrl;
  import accel_seq_ctrl_pkg::*;

  localparam int NN = 4, NW = 16, NI = 16, PL = 2, TO = 200;
  localparam int TOTAL = NN * NW;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_INPUTS = 2, PH_XMIT = 3, PH_ERROR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  accel_seq_ctrl_if #(.N_NEURONS(NN), .N_WEIGHTS(NW)) bus ();

  accel_seq_ctrl #(
    .N_NEURONS(NN), .N_WEIGHTS(NW), .N_INPUTS(NI), .PIPE_LAT(PL), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0, errors = 0;
  int wq[$], mq[$], tq[$];
  int m_phase = PH_IDLE, m_addr = 0, m_in = 0;
  int exp_starts = 0, start_seen = 0, n_writes = 0, cyc = 0, last_mac_cyc = 0;
  int pulses, exp_v;
  bit m_loaded = 0, m_err = 0, mon_en = 0, uart_req = 0, uart_pending = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got strobe value %0d expected no strobe", name, act);
  endtask

  // Protocol-level reference: what each received byte should cause.
  task automatic model_byte(input logic [7:0] b);
    case (m_phase)
      PH_IDLE: begin
        if (b == CMD_LOAD) begin
          m_phase = PH_LOAD; m_addr = 0; m_loaded = 0;
        end else if (b == CMD_RUN) begin
          if (m_loaded) begin
            m_phase = PH_INPUTS; m_in = 0; exp_starts++;
          end else begin
            m_phase = PH_ERROR; m_err = 1;
          end
        end
      end
      PH_LOAD: begin
        wq.push_back(m_addr * 256 + int'(b));
        m_addr++;
        if (m_addr == TOTAL) begin
          m_phase = PH_IDLE; m_loaded = 1;
        end
      end
      PH_INPUTS: begin
        mq.push_back(int'(b));
        m_in++;
        if (m_in == NI) begin
          m_phase = PH_XMIT;
          for (int s = 0; s < NN; s++) tq.push_back(s);
          exp_starts++;
        end
      end
      PH_XMIT: m_err = 1;
      default: if (b == CMD_CLR) begin
        m_phase = PH_IDLE; m_err = 0;
      end
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    model_byte(b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic silence(input int n);
    repeat (n) begin @(posedge clk); #1; end
    if (n >= TO && (m_phase == PH_LOAD || m_phase == PH_INPUTS)) begin
      m_phase = PH_ERROR; m_err = 1; m_loaded = 0;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, int'(bus.busy),
          int'(m_phase == PH_LOAD || m_phase == PH_INPUTS || m_phase == PH_XMIT));
    check({tag, "_err"}, int'(bus.err), int'(m_err));
    check({tag, "_loaded"}, int'(bus.loaded), int'(m_loaded));
  endtask

  task automatic check_zeros(input string tag);
    check({tag, "_write_en"}, int'(bus.write_en), 0);
    check({tag, "_write_addr"}, int'(bus.write_addr), 0);
    check({tag, "_write_data"}, int'(bus.write_data), 0);
    check({tag, "_start_compute"}, int'(bus.start_compute), 0);
    check({tag, "_mac_en"}, int'(bus.mac_en), 0);
    check({tag, "_mac_data"}, int'(bus.mac_data), 0);
    check({tag, "_tx_start"}, int'(bus.tx_start), 0);
    check({tag, "_tx_sel"}, int'(bus.tx_sel), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_err"}, int'(bus.err), 0);
    check({tag, "_loaded"}, int'(bus.loaded), 0);
  endtask

  task automatic apply_reset(input string tag, input bit with_byte, input logic [7:0] b);
    reset = 1'b1;
    if (with_byte) begin
      bus.rx_data = b;
      bus.rx_done = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.rx_done = 1'b0;
    check({tag, "_writes_pending"}, wq.size(), 0);
    m_phase = PH_IDLE; m_loaded = 0; m_err = 0;
    tq.delete();
    exp_starts = start_seen;
    check_zeros(tag);
  endtask

  task automatic wait_frame_done(input string tag);
    int k = 0;
    while (!(tq.size() == 0 && start_seen == exp_starts && !uart_pending) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_frame_timeout"}, int'(k >= 3000), 0);
    check({tag, "_start_count"}, start_seen, exp_starts);
    m_phase = PH_INPUTS;
    m_in = 0;
  endtask

  task automatic wait_tx_busy(input string tag);
    int k = 0;
    while (!bus.tx_busy && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_busy_timeout"}, int'(k >= 500), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      pulses = int'(bus.write_en) + int'(bus.start_compute) + int'(bus.mac_en) + int'(bus.tx_start);
      if (pulses != 0) check("pulse_exclusive", int'(pulses > 1), 0);
      if (bus.write_en) begin
        n_writes++;
        if (wq.size() == 0) flag_unexpected("write_en", int'(bus.write_addr) * 256 + int'(bus.write_data));
        else check("write_addr_data", int'(bus.write_addr) * 256 + int'(bus.write_data), wq.pop_front());
      end
      if (bus.mac_en) begin
        last_mac_cyc = cyc;
        if (mq.size() == 0) flag_unexpected("mac_en", int'(bus.mac_data));
        else check("mac_data", int'(bus.mac_data), mq.pop_front());
      end
      if (bus.start_compute) start_seen++;
      if (bus.tx_start) begin
        check("tx_start_while_busy", int'(bus.tx_busy), 0);
        check("tx_start_overlap", int'(uart_pending), 0);
        if (tq.size() == 0) flag_unexpected("tx_start", int'(bus.tx_sel));
        else begin
          exp_v = tq.pop_front();
          check("tx_sel", int'(bus.tx_sel), exp_v);
          // mac_en shows in the first DRAIN cycle, tx_start one cycle after DRAIN ends.
          if (exp_v == 0) check("drain_gap", cyc - last_mac_cyc, PL + 1);
        end
        uart_pending = 1;
        uart_req = 1;
      end
    end
  end

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_req) begin
        uart_req = 0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
        uart_pending = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int k;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zeros("reset");
    reset = 1'b0;
    mon_en = 1;
    @(posedge clk); #1;

    // Run without weights, error hold, clear.
    send_byte(CMD_RUN, 2);  check_status("run_unloaded");
    send_byte(8'h11, 2);    check_status("err_hold");
    send_byte(CMD_CLR, 2);  check_status("err_clear");

    // Full load with address-valued data.
    n_writes = 0;
    send_byte(CMD_LOAD, $urandom_range(1, 3));
    for (int i = 0; i < TOTAL; i++) send_byte(8'(i), $urandom_range(1, 3));
    check_status("load_full");
    check("load_writes", n_writes, TOTAL);

    // Unrelated bytes in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      if (b == CMD_LOAD || b == CMD_RUN) b = 8'h00;
      send_byte(b, 2);
    end
    check_status("idle_ignore");

    // Two continuous frames; second one gets a stray byte while a transmit is in flight.
    send_byte(CMD_RUN, 1);
    for (int i = 0; i < NI; i++) send_byte(8'($urandom), $urandom_range(1, 3));
    wait_frame_done("frame1");
    check_status("frame1");
    for (int i = 0; i < NI; i++) send_byte(8'($urandom), $urandom_range(1, 3));
    wait_tx_busy("frame2");
    send_byte(8'($urandom), 1);
    wait_frame_done("frame2");
    check_status("frame2");

    // Stall mid-frame in RUN.
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), $urandom_range(1, 3));
    silence(TO + 20);
    check_status("run_timeout");
    send_byte(CMD_CLR, 2);
    check_status("clr_after_run_timeout");

    // Partial load with one long-but-legal gap, then a stall.
    n_writes = 0;
    send_byte(CMD_LOAD, 1);
    for (int i = 0; i < 30; i++) send_byte(8'($urandom), (i == 10) ? TO - 3 : $urandom_range(1, 3));
    check("partial_load_status_busy", int'(bus.busy), 1);
    silence(TO + 20);
    check_status("load_timeout");
    check("partial_writes", n_writes, 30);
    send_byte(CMD_CLR, 2);

    // Reload random weights, run a frame and reset during transmit.
    send_byte(CMD_LOAD, 1);
    for (int i = 0; i < TOTAL; i++) send_byte(8'($urandom), $urandom_range(1, 3));
    check_status("reload");
    send_byte(CMD_RUN, 1);
    for (int i = 0; i < NI; i++) send_byte(8'($urandom), $urandom_range(1, 3));
    wait_tx_busy("frame3");
    apply_reset("reset_send", 0, 8'h00);
    k = 0;
    while (uart_pending && k < 100) begin @(posedge clk); #1; k++; end
    check("uart_idle_after_reset", int'(uart_pending), 0);

    // Reset coincident with the 41st load byte.
    send_byte(CMD_LOAD, 1);
    for (int i = 0; i < 40; i++) send_byte(8'(i), $urandom_range(1, 3));
    apply_reset("reset_load", 1, 8'd40);
    send_byte(CMD_RUN, 2);
    check_status("run_after_reset");

    repeat (5) @(posedge clk);
    #1;
    check("writes_left", wq.size(), 0);
    check("macs_left", mq.size(), 0);
    check("tx_left", tq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_seq_ctrl.md
ACCEL_SEQ_CTRL -- requirements
Module: accel_seq_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- N_NEURONS, 4, neurons in layer
- N_WEIGHTS, 16, weights per neuron; TOTAL = N_NEURONS*N_WEIGHTS
- N_INPUTS, 16, input bytes per inference frame
- PIPE_LAT, 2, MAC pipeline drain cycles
- TIMEOUT, 100000, max idle cycles between bytes inside LOAD/RUN
- ADDR_W, clog2(TOTAL), weight address width
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- rx_done  in  1  one-cycle pulse, new UART byte valid
- rx_data  in  8  received byte, valid with rx_done
- tx_busy  in  1  UART transmitter busy
- write_en  out  1  weight memory write strobe
- write_addr  out  ADDR_W  weight write address
- write_data  out  8  weight byte
- start_compute  out  1  one-cycle accumulator clear pulse
- mac_en  out  1  one-cycle input-byte strobe to MAC array
- mac_data  out  8  input byte to MAC array
- tx_start  out  1  one-cycle transmit request
- tx_sel  out  clog2(N_NEURONS)  neuron result selected for transmit
- busy  out  1  high in any state except IDLE and ERR
- err  out  1  sticky error flag
- loaded  out  1  complete weight set present

Function
REQ-003 States: IDLE, LOAD, START, RUN, DRAIN, SEND, SEND_WAIT, ERR; encoding in package.
REQ-004 IDLE: rx_done with 0xA5 -> LOAD, write address counter = 0, loaded cleared; 0x5A with loaded=1 -> START; 0x5A with loaded=0 -> ERR; other bytes ignored.
REQ-005 LOAD: each rx_done -> write_en high exactly the next cycle, write_addr = current count, write_data = rx_data; count increments after each write.
REQ-006 LOAD: write at address TOTAL-1 -> IDLE and loaded=1 on the same edge as that write; no address wrap beyond TOTAL-1.
REQ-007 START: start_compute high one cycle, input counter = 0 -> RUN.
REQ-008 RUN: each rx_done -> mac_en high next cycle with mac_data = rx_data; N_INPUTS-th byte -> DRAIN.
REQ-009 DRAIN: exactly PIPE_LAT cycles, then SEND with tx_sel = 0.
REQ-010 SEND: when tx_busy=0, tx_start high one cycle -> SEND_WAIT; SEND_WAIT waits for tx_busy high then low; then tx_sel increments -> SEND, or after tx_sel = N_NEURONS-1 -> START (continuous frames).
REQ-011 rx_done in START, DRAIN, SEND, SEND_WAIT: byte dropped, err set, state unchanged.
REQ-012 Timeout: gap counter clears on rx_done and on entry to LOAD/RUN; reaching TIMEOUT-1 in LOAD or RUN -> ERR, loaded cleared.
REQ-013 ERR: err=1; only rx_done with 0xC3 -> IDLE and clears err; loaded stays 0.
REQ-014 write_en, start_compute, mac_en, tx_start: never more than one high in a cycle; each a single-cycle pulse.

Reset
REQ-015 reset high at a clk edge -> IDLE, all counters 0, all outputs 0 (err=0, loaded=0), from any state, including mid-LOAD and mid-SEND.
REQ-016 reset takes priority over rx_done in the same cycle.

Structure
REQ-017 Shared package holds state encoding, command bytes (CMD_LOAD=0xA5, CMD_RUN=0x5A, CMD_CLR=0xC3) and default parameter values.
REQ-018 One sub-module, gap_timer (timeout counter with clear and expire outputs); all else inline.

Verification
REQ-019 CMD_LOAD + 64 bytes 0x00..0x3F -> 64 write_en pulses, addr 0..63, data = addr, loaded=1, back in IDLE.
REQ-020 CMD_RUN with loaded=0 -> err=1, state ERR; byte 0xC3 -> IDLE, err=0.
REQ-021 Load, CMD_RUN, 16 input bytes -> start_compute 1 pulse, 16 mac_en pulses, 2 DRAIN cycles, tx_start ×4 with tx_sel 0..3 each gated on tx_busy falling, then start_compute again.
REQ-022 Load 30 bytes then silence TIMEOUT cycles -> ERR, loaded=0, no further write_en.
REQ-023 rx_done during SEND_WAIT -> err=1, transmit sequence completes unaffected.
REQ-024 reset asserted at byte 40 of LOAD, coincident with rx_done -> IDLE, no write_en, all outputs 0 next cycle.
